// File: rtl/regfile_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_arbiter_if
// Purpose  : Two-requester request/ack bus between clients and the arbiter.
// Revision : 1.0
// ============================================================================
interface regfile_arbiter_if #(
    parameter int DW = 16,
    parameter int AW = 3
);
    logic [1:0]      req;
    logic [3:0]      op;
    logic [2*AW-1:0] addr;
    logic [2*AW-1:0] src;
    logic [2*DW-1:0] wdata;
    logic [1:0]      ack;
    logic [DW-1:0]   rdata;
    logic            busy;

    modport master (
        output req, op, addr, src, wdata,
        input  ack, rdata, busy
    );

    modport slave (
        input  req, op, addr, src, wdata,
        output ack, rdata, busy
    );
endinterface
`default_nettype wire

// File: rtl/regfile_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_arbiter
// Purpose  : Round-robin arbiter and op sequencer for an 8x16 register file.
// Revision : 1.0
// ============================================================================
module regfile_arbiter #(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    regfile_arbiter_if.slave   bus,
    output logic [DW-1:0]      rf_data_in,
    output logic [AW-1:0]      rf_writenum,
    output logic               rf_write,
    output logic [AW-1:0]      rf_readnum,
    input  wire logic [DW-1:0] rf_data_out
);

    localparam logic [1:0] c_OP_READ  = 2'b00;
    localparam logic [1:0] c_OP_WRITE = 2'b01;
    localparam logic [1:0] c_OP_COPY  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_WRITE   = 3'd2,
        S_COPY_RD = 3'd3,
        S_COPY_WR = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t        r_state;
    logic          r_last;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_rdata;
    logic [1:0]    r_ack;
    logic          r_busy;
    logic [DW-1:0] r_rf_data_in;
    logic [AW-1:0] r_rf_writenum;
    logic          r_rf_write;
    logic [AW-1:0] r_rf_readnum;

    logic          w_any_req;
    logic          w_grant;
    logic [1:0]    w_sel_op;
    logic [AW-1:0] w_sel_addr;
    logic [AW-1:0] w_sel_src;
    logic [DW-1:0] w_sel_wdata;

    // Single requester wins outright; on contention the one not served last wins.
    always_comb begin
        w_any_req = |bus.req;
        w_grant   = bus.req[1];
        if (bus.req == 2'b11) begin
            w_grant = ~r_last;
        end
        w_sel_op    = w_grant ? bus.op[3:2]          : bus.op[1:0];
        w_sel_addr  = w_grant ? bus.addr[2*AW-1:AW]  : bus.addr[AW-1:0];
        w_sel_src   = w_grant ? bus.src[2*AW-1:AW]   : bus.src[AW-1:0];
        w_sel_wdata = w_grant ? bus.wdata[2*DW-1:DW] : bus.wdata[DW-1:0];
    end

    // Outputs are registered with the value they must hold in the next state.
    // r_rf_data_in doubles as the copy temporary: it captures the source word
    // in COPY_RD and presents it during COPY_WR.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_last        <= 1'b1;
            r_addr        <= '0;
            r_rdata       <= '0;
            r_ack         <= '0;
            r_busy        <= 1'b0;
            r_rf_data_in  <= '0;
            r_rf_writenum <= '0;
            r_rf_write    <= 1'b0;
            r_rf_readnum  <= '0;
        end else begin
            r_ack         <= '0;
            r_rf_data_in  <= '0;
            r_rf_writenum <= '0;
            r_rf_write    <= 1'b0;
            r_rf_readnum  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_last <= w_grant;
                        r_addr <= w_sel_addr;
                        r_busy <= 1'b1;
                        case (w_sel_op)
                            c_OP_READ: begin
                                r_state      <= S_READ;
                                r_rf_readnum <= w_sel_addr;
                            end
                            c_OP_WRITE: begin
                                r_state       <= S_WRITE;
                                r_rf_write    <= 1'b1;
                                r_rf_writenum <= w_sel_addr;
                                r_rf_data_in  <= w_sel_wdata;
                            end
                            c_OP_COPY: begin
                                r_state      <= S_COPY_RD;
                                r_rf_readnum <= w_sel_src;
                            end
                            default: begin
                                r_state        <= S_DONE;
                                r_ack[w_grant] <= 1'b1;
                            end
                        endcase
                    end
                end
                S_READ: begin
                    r_rdata       <= rf_data_out;
                    r_state       <= S_DONE;
                    r_ack[r_last] <= 1'b1;
                end
                S_WRITE: begin
                    r_state       <= S_DONE;
                    r_ack[r_last] <= 1'b1;
                end
                S_COPY_RD: begin
                    r_state       <= S_COPY_WR;
                    r_rf_write    <= 1'b1;
                    r_rf_writenum <= r_addr;
                    r_rf_data_in  <= rf_data_out;
                end
                S_COPY_WR: begin
                    r_state       <= S_DONE;
                    r_ack[r_last] <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack     = r_ack;
    assign bus.rdata   = r_rdata;
    assign bus.busy    = r_busy;
    assign rf_data_in  = r_rf_data_in;
    assign rf_writenum = r_rf_writenum;
    // Gate so the regfile never commits while reset is asserted.
    assign rf_write    = r_rf_write & reset_n;
    assign rf_readnum  = r_rf_readnum;

endmodule
`default_nettype wire

// File: tb/tb_regfile_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_arbiter
// Purpose  : Scoreboard bench for regfile_arbiter with a behavioural regfile.
// Revision : 1.0
// ============================================================================
module tb_regfile_arbiter;

    localparam logic [1:0] c_RD  = 2'b00;
    localparam logic [1:0] c_WR  = 2'b01;
    localparam logic [1:0] c_CP  = 2'b10;
    localparam logic [1:0] c_NOP = 2'b11;

    typedef struct {
        logic [1:0]  ack;
        logic [15:0] rdata;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] rf_data_in;
    logic [2:0]  rf_writenum;
    logic        rf_write;
    logic [2:0]  rf_readnum;
    logic [15:0] rf_data_out;

    logic [15:0] rf_mem [8] = '{default: 16'h0000};
    logic [15:0] exp_mem [8] = '{default: 16'h0000};
    logic [15:0] last_rd = 16'h0000;

    exp_t q[$];
    int   cyc = 0;
    int   wr_pulses = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    regfile_arbiter_if #(.DW(16), .AW(3)) bus ();

    regfile_arbiter #(.DW(16), .AW(3)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .rf_data_in  (rf_data_in),
        .rf_writenum (rf_writenum),
        .rf_write    (rf_write),
        .rf_readnum  (rf_readnum),
        .rf_data_out (rf_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rf_write) rf_mem[rf_writenum] <= rf_data_in;
    end
    assign rf_data_out = rf_mem[rf_readnum];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n) begin
            if (rf_write) wr_pulses++;
            if (bus.ack != 2'b00) begin
                if (q.size() == 0) begin
                    check("unexpected_ack", {30'd0, bus.ack}, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("ack_vector", {30'd0, bus.ack}, {30'd0, e.ack});
                    check("rdata", {16'd0, bus.rdata}, {16'd0, e.rdata});
                    if (e.due >= 0) check("ack_latency", cyc, e.due);
                end
            end
        end
    end

    task automatic wait_ack(input int who);
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (k == 0) check("busy_during_op", {31'd0, bus.busy}, 32'd1);
            if (bus.ack[who]) seen = 1'b1;
        end
        if (!seen) check("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input int who, input logic [1:0] opc, input logic [2:0] a,
                          input logic [2:0] s, input logic [15:0] d, input int lat);
        exp_t e;
        @(negedge clk);
        bus.op[2*who +: 2]    = opc;
        bus.addr[3*who +: 3]  = a;
        bus.src[3*who +: 3]   = s;
        bus.wdata[16*who +: 16] = d;
        bus.req[who] = 1'b1;
        case (opc)
            c_RD: last_rd = exp_mem[a];
            c_WR: exp_mem[a] = d;
            c_CP: exp_mem[a] = exp_mem[s];
            default: ;
        endcase
        e.ack   = 2'b01 << who;
        e.rdata = last_rd;
        e.due   = cyc + lat;
        q.push_back(e);
        wait_ack(who);
        bus.req[who] = 1'b0;
    endtask

    initial begin
        int   t0;
        int   n;
        int   wr_snap;
        exp_t e;

        // Reset held with both requesters asking to write.
        bus.req   = 2'b11;
        bus.op    = {c_WR, c_WR};
        bus.addr  = {3'd7, 3'd0};
        bus.src   = '0;
        bus.wdata = {16'hDEAD, 16'hDEAD};
        repeat (2) @(negedge clk);
        check("reset_ack", {30'd0, bus.ack}, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_rf_write", {31'd0, rf_write}, 32'd0);
        check("reset_rdata", {16'd0, bus.rdata}, 32'd0);

        // Release with both requesting NOPs: requester 0 must win.
        reset_n = 1'b1;
        bus.op  = {c_NOP, c_NOP};
        e.ack = 2'b01; e.rdata = 16'h0000; e.due = cyc + 1;
        q.push_back(e);
        wait_ack(0);
        bus.req = 2'b00;

        run_op(0, c_WR, 3'd3, 3'd0, 16'h00A5, 2);
        run_op(0, c_RD, 3'd3, 3'd0, 16'h0000, 2);

        run_op(0, c_WR, 3'd5, 3'd0, 16'h1234, 2);
        run_op(1, c_CP, 3'd2, 3'd5, 16'h0000, 3);
        run_op(0, c_RD, 3'd2, 3'd0, 16'h0000, 2);
        run_op(1, c_RD, 3'd5, 3'd0, 16'h0000, 2);

        // Contention: both hold write requests for four grants.
        @(negedge clk);
        bus.op    = {c_WR, c_WR};
        bus.addr  = {3'd7, 3'd0};
        bus.wdata = {16'h0007, 16'h0001};
        bus.req   = 2'b11;
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            e.ack = (i % 2 == 0) ? 2'b01 : 2'b10;
            e.rdata = last_rd;
            e.due = t0 + 2 + 3 * i;
            q.push_back(e);
        end
        exp_mem[0] = 16'h0001;
        exp_mem[7] = 16'h0007;
        n = 0;
        for (int k = 0; k < 40 && n < 4; k++) begin
            @(negedge clk);
            if (bus.ack != 2'b00) n++;
        end
        bus.req = 2'b00;
        check("contention_ack_count", n, 4);
        run_op(0, c_RD, 3'd0, 3'd0, 16'h0000, 2);
        run_op(1, c_RD, 3'd7, 3'd0, 16'h0000, 2);

        // Reset in COPY_RD of copy R5 -> R6 must leave R6 intact.
        run_op(0, c_WR, 3'd6, 3'd0, 16'hBEEF, 2);
        @(negedge clk);
        bus.op[3:2] = c_CP;
        bus.addr[5:3] = 3'd6;
        bus.src[5:3] = 3'd5;
        bus.req = 2'b10;
        @(negedge clk);
        reset_n = 1'b0;
        bus.req = 2'b00;
        repeat (2) @(negedge clk);
        check("midreset_busy", {31'd0, bus.busy}, 32'd0);
        check("midreset_ack", {30'd0, bus.ack}, 32'd0);
        reset_n = 1'b1;
        last_rd = 16'h0000;
        repeat (3) @(negedge clk);
        check("abort_r6_kept", {16'd0, rf_mem[6]}, 32'h0000BEEF);
        run_op(1, c_RD, 3'd6, 3'd0, 16'h0000, 2);

        // NOP: no write strobe, rdata untouched.
        wr_snap = wr_pulses;
        run_op(0, c_NOP, 3'd1, 3'd0, 16'hFFFF, 1);
        check("nop_no_write", wr_pulses, wr_snap);
        check("nop_r1_kept", {16'd0, rf_mem[1]}, 32'd0);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/regfile_arbiter.md
# regfile_arbiter

Sequencing controller and two-requester arbiter for the 8 x 16-bit register file (`regfile`: ports data_in, writenum, write, readnum, clk, data_out). Grants the regfile's single write port and single read port to one requester at a time with round-robin fairness. Runs each granted operation (read, write or register-to-register copy) as a fixed multi-cycle sequence and returns completion with a one-cycle ack. Sits between the regfile and its clients (datapath control, debug/loader port).

## Interface
Parameters:
- DW, 16, data width; matches regfile word width
- AW, 3, register index width (2^AW registers)

Ports (requester i occupies slice i of each packed vector, i = 0,1):
- clk  in  1  single clock, rising-edge
- reset_n  in  1  synchronous, active-low reset
- req  in  2  request per requester; held high until ack
- op  in  4  op[2i+1:2i]: 00 read, 01 write, 10 copy, 11 NOP
- addr  in  2*AW  read address (read), destination (write/copy)
- src  in  2*AW  copy source register; ignored otherwise
- wdata  in  2*DW  write data (write op)
- ack  out  2  one-cycle completion pulse, at most one bit high
- rdata  out  DW  read result; valid in ack cycle, held until next read
- busy  out  1  high whenever state != IDLE
- rf_data_in  out  DW  to regfile data_in
- rf_writenum  out  AW  to regfile writenum
- rf_write  out  1  to regfile write
- rf_readnum  out  AW  to regfile readnum
- rf_data_out  in  DW  from regfile data_out (combinational read of rf_readnum)

## Operation
- States: IDLE, READ, WRITE, COPY_RD, COPY_WR, DONE.
- IDLE: if any req bit high, select grantee g, latch op/addr/src/wdata of g into internal registers, set last = g, go to READ / WRITE / COPY_RD / DONE per op (NOP goes straight to DONE).
- Arbitration: one requester -> grant it. Both -> grant the one != last. last resets to 1, so requester 0 wins the first contention.
- READ: rf_readnum = addr; rdata <= rf_data_out at cycle end; -> DONE.
- WRITE: rf_write = 1, rf_writenum = addr, rf_data_in = wdata; regfile commits at cycle end; -> DONE.
- COPY_RD: rf_readnum = src; tmp <= rf_data_out; -> COPY_WR.
- COPY_WR: rf_write = 1, rf_writenum = addr, rf_data_in = tmp; -> DONE. src == addr is legal and rewrites the same value.
- DONE: ack[g] = 1 for exactly this cycle; -> IDLE.
- rdata changes only on READ; write, copy and NOP leave it unchanged.
- rf_* outputs are 0 in every state that does not use them. rf_write is high only in WRITE/COPY_WR and is gated with reset_n, so no write occurs while reset_n is low.
- Requester contract: after seeing ack, drop req or present a new request by the next cycle. Operands may change after grant because they are latched.

## Timing
- Reset (reset_n low at rising edge): state IDLE, last = 1, tmp = 0, rdata = 0. Outputs ack = 0, busy = 0, all rf_* = 0.
- Reset mid-operation aborts the sequence: no ack, no further write. A copy aborted in COPY_RD leaves the destination unmodified.
- Latency from the IDLE cycle in which req is sampled: read/write ack at cycle +2; copy ack at +3; NOP ack at +1.
- Write visible through the regfile from cycle +2 (ack cycle) onward.
- Back-to-back throughput: one IDLE cycle between operations; continuous contention alternates grants 0,1,0,1.
- A req arriving while busy waits; no request is dropped or reordered within a requester.

## Test plan
- Reset: hold reset_n low 2 cycles with req = 2'b11 -> ack = 0, busy = 0, rf_write = 0, rdata = 0; release -> requester 0 granted first.
- Write/read: req0 write addr 3, wdata 16'h00A5 -> ack[0] at +2; then req0 read addr 3 -> ack[0] at +2 with rdata = 16'h00A5.
- Copy: R5 = 16'h1234 via write, then req1 copy src 5 -> addr 2 -> ack[1] at +3; read R2 = 16'h1234; R5 unchanged.
- Contention: both requesters hold write requests (R0 <= 16'h0001, R7 <= 16'h0007), reissued after each ack -> acks alternate 0,1,0,1; final R0 = 1, R7 = 7.
- Reset mid-copy: assert reset_n low during COPY_RD of copy 5 -> 6, R6 preloaded 16'hBEEF -> no ack; R6 still 16'hBEEF.
- NOP: op 11 from requester 0 -> ack[0] at +1, rf_write never high, rdata unchanged.
